// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cla_pkg
//  Purpose  : Shared definitions for the serial carry-look-ahead adder:
//             FSM state encoding and the slice width.
//  Config   : CLA_SERIAL_SUB_EN (consumed by the adder, not used here)
//  Revision : 1.0 - initial release
// ============================================================================
package cla_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bits processed per cycle by the look-ahead slice
    localparam int SLICE_W = 4;

endpackage : cla_pkg
`default_nettype wire

// File: rtl/cla_serial_adder_if.sv
`default_nettype none
// ============================================================================
//  Module   : cla_serial_adder_if
//  Purpose  : Operand/result handshake bundle for cla_serial_adder.
//  Ports    : in_valid/in_ready/a/b/cin[/sub] - operand side
//             out_valid/out_ready/sum/cout    - result side
//             busy                            - adder is RUN or DONE
//  Modports : master - producer/consumer view, slave - adder view
//  Config   : CLA_SERIAL_SUB_EN adds the 1-bit 'sub' operand-side signal
//  Revision : 1.0 - initial release
// ============================================================================
interface cla_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CLA_SERIAL_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

`ifdef CLA_SERIAL_SUB_EN
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`endif

endinterface : cla_serial_adder_if
`default_nettype wire

// File: rtl/cla_serial_adder_cla4_slice.sv
`default_nettype none
// ============================================================================
//  Module   : cla4_slice
//  Purpose  : Combinational 4-bit carry-look-ahead adder slice. All internal
//             carries are formed directly from generate/propagate terms and
//             the slice carry in, so no ripple path exists inside the slice.
//  Ports    : a4, b4 (in, 4)  - slice operands
//             ci     (in, 1)  - slice carry in
//             s4     (out, 4) - slice sum
//             co     (out, 1) - slice carry out
//  Revision : 1.0 - initial release
// ============================================================================
module cla4_slice
    import cla_pkg::*;
(
    input  wire logic [SLICE_W-1:0] a4,
    input  wire logic [SLICE_W-1:0] b4,
    input  wire logic               ci,
    output logic      [SLICE_W-1:0] s4,
    output logic                    co
);

    logic [SLICE_W-1:0] w_g;
    logic [SLICE_W-1:0] w_p;
    logic [SLICE_W-1:0] w_c;

    assign w_g = a4 & b4;
    assign w_p = a4 ^ b4;

    // Look-ahead carries into each bit position
    assign w_c[0] = ci;
    assign w_c[1] = w_g[0] | (w_p[0] & ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & ci);

    assign co = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
              | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

    assign s4 = w_p ^ w_c;

endmodule : cla4_slice
`default_nettype wire

// File: rtl/cla_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : cla_serial_adder
//  Purpose  : Multi-cycle WIDTH-bit adder. Operands are latched on accept and
//             summed one 4-bit slice per cycle, LSB first, through a single
//             carry-look-ahead slice; the slice carry is held in a register
//             between cycles. Result is presented with valid/ready.
//  Params   : WIDTH - operand/sum width, multiple of 4 and >= 4
//  Ports    : clk   (in)  - rising-edge clock
//             rst_n (in)  - synchronous active-low reset
//             bus   (slave modport of cla_serial_adder_if):
//               in_valid/in_ready/a/b/cin[/sub], out_valid/out_ready/sum/
//               cout, busy
//  Config   : CLA_SERIAL_SUB_EN - adds 'sub'; when set the adder computes
//             A-B (B inverted, carry seeded with 1, cin ignored); cout=1
//             then means no borrow.
//  Revision : 1.0 - initial release
// ============================================================================
module cla_serial_adder #(
    parameter int WIDTH = 16
) (
    input wire logic         clk,
    input wire logic         rst_n,
    cla_serial_adder_if.slave bus
);
    import cla_pkg::*;

    localparam int NIBBLES = WIDTH / SLICE_W;
    localparam int c_cnt_w = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NIBBLES - 1);

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
`ifdef CLA_SERIAL_SUB_EN
    logic               r_sub;
`endif

    logic [SLICE_W-1:0] w_a4;
    logic [SLICE_W-1:0] w_b4;
    logic [SLICE_W-1:0] w_s4;
    logic               w_co;
    logic               w_start_carry;

    // Current slice of the latched operands
    assign w_a4 = r_a[r_cnt*SLICE_W +: SLICE_W];
`ifdef CLA_SERIAL_SUB_EN
    // Subtraction is A + ~B + 1: invert B here, seed the carry with 1 on accept
    assign w_b4          = r_b[r_cnt*SLICE_W +: SLICE_W] ^ {SLICE_W{r_sub}};
    assign w_start_carry = bus.sub | bus.cin;
`else
    assign w_b4          = r_b[r_cnt*SLICE_W +: SLICE_W];
    assign w_start_carry = bus.cin;
`endif

    cla4_slice u_slice (
        .a4 (w_a4),
        .b4 (w_b4),
        .ci (r_carry),
        .s4 (w_s4),
        .co (w_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef CLA_SERIAL_SUB_EN
            r_sub       <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_carry    <= w_start_carry;
`ifdef CLA_SERIAL_SUB_EN
                        r_sub      <= bus.sub;
`endif
                        r_cnt      <= '0;
                        r_state    <= ST_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_sum[r_cnt*SLICE_W +: SLICE_W] <= w_s4;
                    r_carry <= w_co;
                    if (r_cnt == c_last) begin
                        r_cout      <= w_co;
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Result held until the consumer takes it; no accept here
                    if (bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.busy      = r_busy;

endmodule : cla_serial_adder
`default_nettype wire
